// File: rtl/multicore_mem_arbiter.sv
// Round-robin arbiter that serialises per-core memory requests onto a single
// RAM port. One transaction is in flight at a time: IDLE -> BUSY -> RESP -> IDLE.
module multicore_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          req_vec,
  input  logic [NUM_CORES-1:0]          we_vec,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr_flat,
  input  logic [NUM_CORES*DATA_W-1:0]   wdata_flat,
  output logic [NUM_CORES-1:0]          grant_vec,
  output logic [NUM_CORES-1:0]          done_vec,
  output logic                          err,
  output logic [DATA_W-1:0]             rdata,
  output logic                          ram_req,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic                          ram_ready,
  input  logic [DATA_W-1:0]             ram_rdata
);

  localparam int PW = $clog2(NUM_CORES);
  localparam int CW = 16;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   sel;
  logic            any_req;
  logic [CW-1:0]   cnt;
  logic            ram_done;
  logic            timed_out;

  // Round-robin pick: first requesting core at or above ptr, wrapping around.
  always_comb begin
    int unsigned j;
    logic        found;
    logic [PW-1:0] idx;
    sel   = '0;
    found = 1'b0;
    j     = 0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      j   = (32'(ptr) + i) % 32'(NUM_CORES);
      idx = PW'(j);
      if (!found && req_vec[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Completion qualifiers for BUSY; a real ready wins over a coincident timeout.
  always_comb begin
    any_req   = |req_vec;
    ram_done  = (state == BUSY) && ram_ready;
    timed_out = (state == BUSY) && !ram_ready && (cnt == CW'(TIMEOUT));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (ram_done || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs, request capture, timeout counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_vec <= '0;
      done_vec  <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cnt       <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_vec <= NUM_CORES'(1) << sel;
            ram_req   <= 1'b1;
            ram_we    <= we_vec[sel];
            ram_addr  <= addr_flat[sel*ADDR_W +: ADDR_W];
            ram_wdata <= wdata_flat[sel*DATA_W +: DATA_W];
            cnt       <= CW'(1);
            ptr       <= (sel == PW'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
          end
        end
        BUSY: begin
          if (ram_done) begin
            ram_req  <= 1'b0;
            err      <= 1'b0;
            rdata    <= ram_we ? '0 : ram_rdata;
            done_vec <= grant_vec;
          end else if (timed_out) begin
            ram_req  <= 1'b0;
            err      <= 1'b1;
            rdata    <= '0;
            done_vec <= grant_vec;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          grant_vec <= '0;
          done_vec  <= '0;
          err       <= 1'b0;
          cnt       <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Directed bench for multicore_mem_arbiter with a queue-based scoreboard:
// stimulus pushes expected grants/responses, a negedge monitor pops and compares.
module tb_multicore_mem_arbiter;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NC-1:0]     req_vec = '0;
  logic [NC-1:0]     we_vec = '0;
  logic [NC*AW-1:0]  addr_flat = '0;
  logic [NC*DW-1:0]  wdata_flat = '0;
  logic [NC-1:0]     grant_vec;
  logic [NC-1:0]     done_vec;
  logic              err;
  logic [DW-1:0]     rdata;
  logic              ram_req;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic              ram_ready;
  logic [DW-1:0]     ram_rdata;

  logic              man_ready = 1'b0;
  logic [DW-1:0]     man_rdata = '0;
  logic              auto_en = 1'b0;

  // Auto mode: RAM answers one cycle after the request with addr ^ 0x5A5A0000.
  assign ram_ready = man_ready | (auto_en & ram_req);
  assign ram_rdata = auto_en ? (ram_addr ^ 32'h5A5A_0000) : man_rdata;

  multicore_mem_arbiter #(
    .NUM_CORES(NC),
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_vec(req_vec),
    .we_vec(we_vec),
    .addr_flat(addr_flat),
    .wdata_flat(wdata_flat),
    .grant_vec(grant_vec),
    .done_vec(done_vec),
    .err(err),
    .rdata(rdata),
    .ram_req(ram_req),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_ready(ram_ready),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NC-1:0] done;
    logic          err;
    logic [DW-1:0] rdata;
  } resp_t;

  logic [NC-1:0] exp_grant[$];
  resp_t         exp_resp[$];
  int            total = 0;
  int            bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_resp(input logic [NC-1:0] d, input logic e, input logic [DW-1:0] r);
    resp_t x;
    x.done  = d;
    x.err   = e;
    x.rdata = r;
    exp_resp.push_back(x);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_resp.size() == 0 && exp_grant.size() == 0) break;
      tick();
    end
    check("drain_wait", 64'(exp_resp.size() + exp_grant.size()), 64'd0);
  endtask

  // Monitor: checks one-hot invariants, grant order with an idle gap, and responses.
  logic [NC-1:0] prev_grant = '0;
  int            idle_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_grant = '0;
      idle_run   = 0;
      if (done_vec != '0) check("done_in_reset", 64'(done_vec), 64'd0);
    end else begin
      check("grant_onehot0", 64'($onehot0(grant_vec)), 64'd1);
      check("done_onehot0", 64'($onehot0(done_vec)), 64'd1);
      if (done_vec != '0) begin
        if (exp_resp.size() == 0) begin
          check("unexpected_done", 64'(done_vec), 64'd0);
        end else begin
          resp_t x;
          x = exp_resp.pop_front();
          check("done_vec", 64'(done_vec), 64'(x.done));
          check("done_eq_grant", 64'(grant_vec), 64'(x.done));
          check("err", 64'(err), 64'(x.err));
          check("rdata", 64'(rdata), 64'(x.rdata));
        end
      end
      if (grant_vec != '0 && prev_grant == '0) begin
        check("idle_gap", 64'(idle_run >= 1), 64'd1);
        if (exp_grant.size() == 0) check("unexpected_grant", 64'(grant_vec), 64'd0);
        else check("grant_order", 64'(grant_vec), 64'(exp_grant.pop_front()));
      end
      idle_run   = (grant_vec == '0) ? idle_run + 1 : 0;
      prev_grant = grant_vec;
    end
  end

  initial begin
    int n;

    // Reset state
    #1 rst = 1'b1;
    #3;
    check("rst_ctrl", 64'({grant_vec, done_vec, err, ram_req, ram_we}), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_wdata", 64'(ram_wdata), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single read from core 2, three-cycle latency
    addr_flat[2*AW +: AW] = 32'h0000_0010;
    req_vec = 4'b0100;
    exp_grant.push_back(4'b0100);
    push_resp(4'b0100, 1'b0, 32'hDEAD_BEEF);
    tick();
    check("rd_ram_req", 64'(ram_req), 64'd1);
    check("rd_ram_addr", 64'(ram_addr), 64'h10);
    check("rd_ram_we", 64'(ram_we), 64'd0);
    req_vec = '0;
    man_ready = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    tick();
    man_ready = 1'b0;
    check("latency_done", 64'(done_vec), 64'b0100);
    tick();
    check("resp_one_cycle", 64'(done_vec), 64'd0);
    wait_drain(10);

    // All four cores request continuously from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NC; i++) begin
      addr_flat[i*AW +: AW] = 32'h100 + 32'(i) * 4;
      we_vec[i] = 1'b0;
    end
    exp_grant.push_back(4'b0001);
    exp_grant.push_back(4'b0010);
    exp_grant.push_back(4'b0100);
    exp_grant.push_back(4'b1000);
    exp_grant.push_back(4'b0001);
    push_resp(4'b0001, 1'b0, 32'h5A5A_0100);
    push_resp(4'b0010, 1'b0, 32'h5A5A_0104);
    push_resp(4'b0100, 1'b0, 32'h5A5A_0108);
    push_resp(4'b1000, 1'b0, 32'h5A5A_010C);
    push_resp(4'b0001, 1'b0, 32'h5A5A_0100);
    auto_en = 1'b1;
    req_vec = 4'b1111;
    for (int i = 0; i < 60; i++) begin
      if (exp_grant.size() == 0) break;
      tick();
    end
    req_vec = '0;
    check("rr_grant_wait", 64'(exp_grant.size()), 64'd0);
    wait_drain(20);
    auto_en = 1'b0;

    // Core 1 write; request fields change after grant
    we_vec[1] = 1'b1;
    addr_flat[1*AW +: AW] = 32'h0000_0020;
    wdata_flat[1*DW +: DW] = 32'hA5A5_A5A5;
    req_vec = 4'b0010;
    exp_grant.push_back(4'b0010);
    push_resp(4'b0010, 1'b0, 32'h0);
    tick();
    wdata_flat[1*DW +: DW] = 32'h1234_5678;
    addr_flat[1*AW +: AW] = 32'h0000_0099;
    we_vec[1] = 1'b0;
    req_vec = '0;
    tick();
    tick();
    check("wr_hold_wdata", 64'(ram_wdata), 64'hA5A5_A5A5);
    check("wr_hold_addr", 64'(ram_addr), 64'h20);
    check("wr_hold_we", 64'(ram_we), 64'd1);
    check("wr_hold_req", 64'(ram_req), 64'd1);
    man_ready = 1'b1;
    man_rdata = 32'hFFFF_FFFF;
    tick();
    man_ready = 1'b0;
    tick();
    wait_drain(10);

    // Timeout: ram_ready held low with TIMEOUT=8
    addr_flat[3*AW +: AW] = 32'h0000_0030;
    we_vec[3] = 1'b0;
    man_rdata = 32'hCAFE_F00D;
    req_vec = 4'b1000;
    exp_grant.push_back(4'b1000);
    push_resp(4'b1000, 1'b1, 32'h0);
    tick();
    req_vec = '0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_req) n++;
      else break;
    end
    check("timeout_req_cycles", 64'(n), 64'd8);
    @(posedge clk);
    #1;
    // ram_ready while idle must not start or finish anything
    man_ready = 1'b1;
    tick();
    tick();
    man_ready = 1'b0;
    check("idle_ready_ignored", 64'({grant_vec, done_vec, ram_req}), 64'd0);
    wait_drain(10);

    // Reset during BUSY, then lowest-index requester wins
    addr_flat[1*AW +: AW] = 32'h0000_0044;
    addr_flat[0*AW +: AW] = 32'h0000_0100;
    we_vec = '0;
    req_vec = 4'b0010;
    exp_grant.push_back(4'b0010);
    tick();
    req_vec = '0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("abort_ctrl", 64'({grant_vec, done_vec, err, ram_req, ram_we}), 64'd0);
    check("abort_addr", 64'(ram_addr), 64'd0);
    check("abort_wdata", 64'(ram_wdata), 64'd0);
    check("abort_rdata", 64'(rdata), 64'd0);
    req_vec = 4'b1001;
    tick();
    tick();
    rst = 1'b0;
    exp_grant.push_back(4'b0001);
    push_resp(4'b0001, 1'b0, 32'h5A5A_0100);
    auto_en = 1'b1;
    tick();
    req_vec = '0;
    wait_drain(10);
    auto_en = 1'b0;
    tick();
    tick();

    check("queues_empty", 64'(exp_resp.size() + exp_grant.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicore_mem_arbiter.md
MULTICORE_MEM_ARBITER -- requirements
Module: multicore_mem_arbiter

Interface
REQ-001 Parameter NUM_CORES, 4, number of requesting cores (2..16).
REQ-002 Parameter ADDR_W, 32, address width.
REQ-003 Parameter DATA_W, 32, data width.
REQ-004 Parameter TIMEOUT, 255, maximum BUSY cycles before abort (1..65535).
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 req_vec  in  NUM_CORES  per-core request level; bit i = core i.
REQ-008 we_vec  in  NUM_CORES  per-core write enable (1 = write, 0 = read).
REQ-009 addr_flat  in  NUM_CORES*ADDR_W  per-core address; core i at [i*ADDR_W +: ADDR_W].
REQ-010 wdata_flat  in  NUM_CORES*DATA_W  per-core write data; same slicing as addr_flat.
REQ-011 grant_vec  out  NUM_CORES  one-hot registered grant; all-zero when idle.
REQ-012 done_vec  out  NUM_CORES  one-cycle completion pulse to the granted core.
REQ-013 err  out  1  timeout flag; valid only while a done_vec bit is high.
REQ-014 rdata  out  DATA_W  shared read data; valid only while a done_vec bit is high.
REQ-015 ram_req  out  1  RAM access request, held until accepted.
REQ-016 ram_we  out  1  RAM write enable.
REQ-017 ram_addr  out  ADDR_W  RAM address.
REQ-018 ram_wdata  out  DATA_W  RAM write data.
REQ-019 ram_ready  in  1  RAM completion, sampled only in BUSY.
REQ-020 ram_rdata  in  DATA_W  RAM read data, valid with ram_ready.

Function
REQ-021 The block SHALL implement FSM states IDLE, BUSY and RESP.
REQ-022 In IDLE with any req_vec bit set, the block SHALL select one core by round-robin, set its grant_vec bit, register that core's we/addr/wdata into ram_we/ram_addr/ram_wdata, set ram_req=1 and enter BUSY on the same edge.
REQ-023 Round-robin SHALL search from index ptr upward with wrap-around; after granting core k, ptr SHALL become (k+1) mod NUM_CORES.
REQ-024 Core request fields SHALL be sampled only at grant; later changes SHALL NOT affect the transaction in flight.
REQ-025 In BUSY, ram_req/ram_we/ram_addr/ram_wdata SHALL be held stable until ram_ready=1 is sampled.
REQ-026 On ram_ready=1 in BUSY, the block SHALL enter RESP and set ram_req=0 and err=0; rdata SHALL take ram_rdata for a read or 0 for a write.
REQ-027 A cycle counter SHALL count BUSY cycles from 1; if it reaches TIMEOUT with ram_ready=0, the block SHALL enter RESP with err=1, rdata=0 and ram_req=0.
REQ-028 If ram_ready=1 on the TIMEOUT cycle, the block SHALL treat it as normal completion (err=0).
REQ-029 In RESP, done_vec SHALL equal grant_vec for exactly one cycle; then grant_vec, done_vec and err SHALL clear and the block SHALL return to IDLE.
REQ-030 IDLE SHALL last at least one cycle between transactions, so a core that drops req on seeing done is never re-granted.
REQ-031 Minimum latency SHALL be 3 cycles: request sampled on edge 1, ram_ready on edge 2, done high on edge 2 to edge 3.
REQ-032 ram_ready outside BUSY SHALL be ignored.
REQ-033 At most one grant_vec bit and one done_vec bit SHALL be high at any time.

Reset
REQ-034 On rst=1, regardless of clk or state, the block SHALL go to IDLE with grant_vec, done_vec, err, rdata, ram_req, ram_we, ram_addr, ram_wdata, counter and ptr all 0.
REQ-035 Reset during BUSY SHALL abort the transaction with no done pulse; ram_req SHALL drop immediately.

Verification
REQ-036 NUM_CORES=4: only core 2 reads addr 0x10, ram_ready one cycle later with ram_rdata 0xDEADBEEF -> grant_vec=0100, then done_vec=0100 with rdata=0xDEADBEEF, err=0.
REQ-037 All four cores request continuously from reset -> grants go in order 0,1,2,3,0, each separated by at least one IDLE cycle.
REQ-038 Core 1 writes 0xA5A5A5A5 to 0x20 and changes wdata during BUSY -> ram_wdata stays 0xA5A5A5A5 and rdata=0 at done.
REQ-039 TIMEOUT=8 with ram_ready held 0 -> ram_req high for 8 cycles, then done pulse with err=1 and rdata=0.
REQ-040 rst asserted mid-BUSY -> all outputs 0 immediately with no done pulse; after release, the first grant goes to the lowest-index requester.
